lfsr_gen: RTL



---
 rtl/lfsr_pkg.sv | 64 ++++++
 rtl/lfsr_gen_period_ctr.sv | 71 +++++++
 rtl/lfsr_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the parametrised Fibonacci LFSR generator.
//   lfsr_default_taps(width) : maximal-length feedback mask for widths 3..32
//   lfsr_next(state, taps, width) : one Fibonacci step, shifting toward the MSB
// Both the RTL and its reference model call these, so that there is one
// definition of the step.
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_MIN_WIDTH = 3;
    localparam int LFSR_MAX_WIDTH = 32;

    // Bit i set means state[i] feeds the XOR. Returns 0 for unsupported widths.
    function automatic logic [31:0] lfsr_default_taps(input int width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // One Fibonacci step: feedback is the parity of the tapped bits and it
    // enters at bit 0 while the register shifts up. Bits at and above width
    // are forced to zero so narrow registers can share this 32-bit helper.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] taps,
                                              input int          width);
        logic        fb;
        logic [31:0] mask;
        fb   = ^(state & taps);
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return ((state << 1) | {31'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_gen_period_ctr.sv
// -----------------------------------------------------------------------------
// lfsr_period_ctr
// Counts LFSR steps since the reference seed was last seen. It raises a
// one-cycle wrap pulse when the state returns to that seed and records the
// cycle length in period.
//   clk, rst          : clock, asynchronous active-low reset
//   step_i            : the shift register advances this cycle
//   restart_i         : a seed load this cycle; it takes a new reference
//   restart_seed_i    : the reference value that restart_i takes
//   next_state_i      : the value that the shift register takes on a step
//   wrap_o            : registered pulse, coincident with out == reference
//   period_o          : step count of the last completed cycle
// -----------------------------------------------------------------------------
module lfsr_period_ctr #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_i,
    input  logic             restart_i,
    input  logic [WIDTH-1:0] restart_seed_i,
    input  logic [WIDTH-1:0] next_state_i,
    output logic             wrap_o,
    output logic [WIDTH-1:0] period_o
);

    logic [WIDTH-1:0] ref_q,    ref_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q,   wrap_d;

    always_comb begin
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        if (restart_i) begin
            ref_d = restart_seed_i;
            cnt_d = '0;
        end else if (step_i) begin
            // A cycle that never comes back lets cnt wrap silently, and
            // period is left untouched.
            if (next_state_i == ref_q) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + WIDTH'(1);
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_q    <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
        end
    end

    assign wrap_o   = wrap_q;
    assign period_o = period_q;

endmodule

// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
// Parametrised Fibonacci LFSR pseudo-random generator. It has a step enable,
// a run-time seed load, all-zero lockup protection and period measurement.
//   clk, rst : clock, asynchronous active-low reset
//   en       : advance one step this cycle
//   load     : load seed_in this cycle (takes priority over en)
//   seed_in  : run-time seed; zero is rejected and SEED is used instead
//   out      : current LFSR state (registered)
//   bit_out  : out[WIDTH-1], serial PRBS bit
//   wrap     : one-cycle pulse when out has returned to the reference seed
//   period   : step count of the last completed cycle
//   lockup   : one-cycle pulse when a zero seed was rejected
// -----------------------------------------------------------------------------
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lockup
);

    // Reject illegal configurations at elaboration. A zero SEED would lock
    // the register in the all-zero state for good.
    if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be non-zero");
    end

    logic [WIDTH-1:0] out_q,    out_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] next_state;
    logic             seed_ok;
    logic [WIDTH-1:0] load_seed;

    assign next_state = WIDTH'(lfsr_next(32'(out_q), 32'(TAPS), WIDTH));
    assign seed_ok    = (seed_in != '0);
    // The value that a load takes, for the shift register and for the reference.
    assign load_seed  = seed_ok ? seed_in : SEED;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        out_d    = out_q;
        lockup_d = 1'b0;
        if (load) begin
            out_d    = load_seed;
            lockup_d = ~seed_ok;
        end else if (en) begin
            out_d = next_state;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= SEED;
            lockup_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            lockup_q <= lockup_d;
        end
    end

    lfsr_period_ctr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_period_ctr (
        .clk            (clk),
        .rst            (rst),
        .step_i         (en & ~load),
        .restart_i      (load),
        .restart_seed_i (load_seed),
        .next_state_i   (next_state),
        .wrap_o         (wrap),
        .period_o       (period)
    );

    assign out     = out_q;
    assign bit_out = out_q[WIDTH-1];
    assign lockup  = lockup_q;

endmodule
